// File: rtl/ingress_cpl_dispatch_if.sv
// ingress_cpl_dispatch_if: completion input stream plus the three consumer output streams.
// slave is the dispatcher's view; master is the driving/observing side.
interface ingress_cpl_dispatch_if #(
    parameter int DATA_W  = 256,
    parameter int KEEP_W  = 8,
    parameter int TUSER_W = 8,
    parameter int TAG_W   = 8
);
    logic [DATA_W-1:0]  cpl_data;
    logic [KEEP_W-1:0]  cpl_keep;
    logic [TUSER_W-1:0] cpl_user;
    logic               cpl_sop;
    logic               cpl_eop;
    logic [TAG_W-1:0]   cpl_tag;
    logic               cpl_valid;
    logic               cpl_rdy;
    logic               rxd_m_axis_tx_tready;
    logic [DATA_W-1:0]  rxd_m_axis_tx_tdata;
    logic [KEEP_W-1:0]  rxd_m_axis_tx_tkeep;
    logic               rxd_m_axis_tx_sop;
    logic               rxd_m_axis_tx_eop;
    logic               rxd_m_axis_tx_tvalid;
    logic [TUSER_W-1:0] rxd_m_axis_tx_tuser;
    logic               rxs_m_axis_tx_tready;
    logic [DATA_W-1:0]  rxs_m_axis_tx_tdata;
    logic [KEEP_W-1:0]  rxs_m_axis_tx_tkeep;
    logic               rxs_m_axis_tx_sop;
    logic               rxs_m_axis_tx_eop;
    logic               rxs_m_axis_tx_tvalid;
    logic [TUSER_W-1:0] rxs_m_axis_tx_tuser;
    logic               txd_m_axis_tx_tready;
    logic [DATA_W-1:0]  txd_m_axis_tx_tdata;
    logic [KEEP_W-1:0]  txd_m_axis_tx_tkeep;
    logic               txd_m_axis_tx_sop;
    logic               txd_m_axis_tx_eop;
    logic               txd_m_axis_tx_tvalid;
    logic [TUSER_W-1:0] txd_m_axis_tx_tuser;

    modport slave (
        input  cpl_data, cpl_keep, cpl_user, cpl_sop, cpl_eop, cpl_tag, cpl_valid,
        output cpl_rdy,
        input  rxd_m_axis_tx_tready, rxs_m_axis_tx_tready, txd_m_axis_tx_tready,
        output rxd_m_axis_tx_tdata, rxd_m_axis_tx_tkeep, rxd_m_axis_tx_sop, rxd_m_axis_tx_eop,
               rxd_m_axis_tx_tvalid, rxd_m_axis_tx_tuser,
        output rxs_m_axis_tx_tdata, rxs_m_axis_tx_tkeep, rxs_m_axis_tx_sop, rxs_m_axis_tx_eop,
               rxs_m_axis_tx_tvalid, rxs_m_axis_tx_tuser,
        output txd_m_axis_tx_tdata, txd_m_axis_tx_tkeep, txd_m_axis_tx_sop, txd_m_axis_tx_eop,
               txd_m_axis_tx_tvalid, txd_m_axis_tx_tuser
    );

    modport master (
        output cpl_data, cpl_keep, cpl_user, cpl_sop, cpl_eop, cpl_tag, cpl_valid,
        input  cpl_rdy,
        output rxd_m_axis_tx_tready, rxs_m_axis_tx_tready, txd_m_axis_tx_tready,
        input  rxd_m_axis_tx_tdata, rxd_m_axis_tx_tkeep, rxd_m_axis_tx_sop, rxd_m_axis_tx_eop,
               rxd_m_axis_tx_tvalid, rxd_m_axis_tx_tuser,
        input  rxs_m_axis_tx_tdata, rxs_m_axis_tx_tkeep, rxs_m_axis_tx_sop, rxs_m_axis_tx_eop,
               rxs_m_axis_tx_tvalid, rxs_m_axis_tx_tuser,
        input  txd_m_axis_tx_tdata, txd_m_axis_tx_tkeep, txd_m_axis_tx_sop, txd_m_axis_tx_eop,
               txd_m_axis_tx_tvalid, txd_m_axis_tx_tuser
    );
endinterface

// File: rtl/ingress_cpl_dispatch.sv
// ingress_cpl_dispatch: routes completion TLPs to rxd/rxs/txd by tag[TAG_W-1:TAG_W-2], drops unrouted ones.
// Optional INGRESS_CPL_STAT_EN adds saturating per-destination packet counters and a drop counter.
module ingress_cpl_dispatch #(
    parameter int DATA_W  = 256,
    parameter int KEEP_W  = 8,
    parameter int TUSER_W = 8,
    parameter int TAG_W   = 8
) (
    input  logic clk,
    input  logic rst_n,
    ingress_cpl_dispatch_if.slave bus,
    output logic cpl_unroute_err
`ifdef INGRESS_CPL_STAT_EN
    ,
    output logic [15:0] stat_rxd_pkts,
    output logic [15:0] stat_rxs_pkts,
    output logic [15:0] stat_txd_pkts,
    output logic [15:0] stat_drop_pkts
`endif
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FWD  = 2'd1;
    localparam logic [1:0] DROP = 2'd2;

    logic [1:0]         state_q, state_d, dest_q, dest_d, odest_q, odest_d;
    logic [DATA_W-1:0]  odata_q, odata_d;
    logic [KEEP_W-1:0]  okeep_q, okeep_d;
    logic [TUSER_W-1:0] ouser_q, ouser_d;
    logic               osop_q, osop_d, oeop_q, oeop_d, ovld_q, ovld_d, err_q, err_d;
    logic [1:0]         tag_dest, cur_dest;
    logic               out_rdy, fwd_beat, acc, load, sop_acc, tag_unused;

    always_comb begin
        tag_dest   = bus.cpl_tag[TAG_W-1 -: 2];
        tag_unused = ^bus.cpl_tag[TAG_W-3:0];
        cur_dest   = (state_q == FWD) ? dest_q : tag_dest;
        out_rdy    = (odest_q == 2'd0) ? bus.rxd_m_axis_tx_tready :
                     (odest_q == 2'd1) ? bus.rxs_m_axis_tx_tready : bus.txd_m_axis_tx_tready;
        fwd_beat   = (state_q == FWD) | ((state_q == IDLE) & bus.cpl_sop & (tag_dest != 2'b11));
        // Dropped beats (unrouted, DROP state, stray non-SOP in IDLE) never wait on the output stage
        bus.cpl_rdy = fwd_beat ? (!ovld_q | out_rdy) : 1'b1;
        acc        = bus.cpl_valid & bus.cpl_rdy;
        load       = acc & fwd_beat;
        sop_acc    = acc & (state_q == IDLE) & bus.cpl_sop;
        err_d      = sop_acc & (tag_dest == 2'b11);
        dest_d     = sop_acc ? tag_dest : dest_q;
        state_d    = (state_q == IDLE) ? ((sop_acc & !bus.cpl_eop) ? ((tag_dest == 2'b11) ? DROP : FWD) : IDLE) :
                     (acc & bus.cpl_eop) ? IDLE : state_q;
        ovld_d     = load | (ovld_q & !out_rdy);
        odest_d    = load ? cur_dest : odest_q;
        odata_d    = load ? bus.cpl_data : odata_q;
        okeep_d    = load ? bus.cpl_keep : okeep_q;
        ouser_d    = load ? bus.cpl_user : ouser_q;
        osop_d     = load ? bus.cpl_sop : osop_q;
        oeop_d     = load ? bus.cpl_eop : oeop_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dest_q  <= 2'd0;
            odest_q <= 2'd0;
            odata_q <= '0;
            okeep_q <= '0;
            ouser_q <= '0;
            osop_q  <= 1'b0;
            oeop_q  <= 1'b0;
            ovld_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
            odest_q <= odest_d;
            odata_q <= odata_d;
            okeep_q <= okeep_d;
            ouser_q <= ouser_d;
            osop_q  <= osop_d;
            oeop_q  <= oeop_d;
            ovld_q  <= ovld_d;
            err_q   <= err_d;
        end
    end

    assign cpl_unroute_err          = err_q;
    assign bus.rxd_m_axis_tx_tvalid = ovld_q & (odest_q == 2'd0);
    assign bus.rxs_m_axis_tx_tvalid = ovld_q & (odest_q == 2'd1);
    assign bus.txd_m_axis_tx_tvalid = ovld_q & (odest_q == 2'd2);
    assign bus.rxd_m_axis_tx_tdata  = odata_q;
    assign bus.rxs_m_axis_tx_tdata  = odata_q;
    assign bus.txd_m_axis_tx_tdata  = odata_q;
    assign bus.rxd_m_axis_tx_tkeep  = okeep_q;
    assign bus.rxs_m_axis_tx_tkeep  = okeep_q;
    assign bus.txd_m_axis_tx_tkeep  = okeep_q;
    assign bus.rxd_m_axis_tx_tuser  = ouser_q;
    assign bus.rxs_m_axis_tx_tuser  = ouser_q;
    assign bus.txd_m_axis_tx_tuser  = ouser_q;
    assign bus.rxd_m_axis_tx_sop    = osop_q;
    assign bus.rxs_m_axis_tx_sop    = osop_q;
    assign bus.txd_m_axis_tx_sop    = osop_q;
    assign bus.rxd_m_axis_tx_eop    = oeop_q;
    assign bus.rxs_m_axis_tx_eop    = oeop_q;
    assign bus.txd_m_axis_tx_eop    = oeop_q;

`ifdef INGRESS_CPL_STAT_EN
    logic [15:0] stat_rxd_q, stat_rxd_d, stat_rxs_q, stat_rxs_d, stat_txd_q, stat_txd_d, stat_drop_q, stat_drop_d;
    logic        done_rxd, done_rxs, done_txd;

    always_comb begin
        done_rxd    = bus.rxd_m_axis_tx_tvalid & bus.rxd_m_axis_tx_tready & oeop_q;
        done_rxs    = bus.rxs_m_axis_tx_tvalid & bus.rxs_m_axis_tx_tready & oeop_q;
        done_txd    = bus.txd_m_axis_tx_tvalid & bus.txd_m_axis_tx_tready & oeop_q;
        stat_rxd_d  = stat_rxd_q + {15'd0, done_rxd & ~&stat_rxd_q};
        stat_rxs_d  = stat_rxs_q + {15'd0, done_rxs & ~&stat_rxs_q};
        stat_txd_d  = stat_txd_q + {15'd0, done_txd & ~&stat_txd_q};
        stat_drop_d = stat_drop_q + {15'd0, err_d & ~&stat_drop_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_rxd_q  <= '0;
            stat_rxs_q  <= '0;
            stat_txd_q  <= '0;
            stat_drop_q <= '0;
        end else begin
            stat_rxd_q  <= stat_rxd_d;
            stat_rxs_q  <= stat_rxs_d;
            stat_txd_q  <= stat_txd_d;
            stat_drop_q <= stat_drop_d;
        end
    end

    assign stat_rxd_pkts  = stat_rxd_q;
    assign stat_rxs_pkts  = stat_rxs_q;
    assign stat_txd_pkts  = stat_txd_q;
    assign stat_drop_pkts = stat_drop_q;
`endif
endmodule

// File: doc/ingress_cpl_dispatch.md
Name: ingress_cpl_dispatch

Overview:
- Packet-level completion router in the PCIe ingress path, between the completion parser front end and the three completion consumers: rx-data, rx-SGL and tx-data.
- Decodes the completion tag on the SOP beat and locks that route for the whole TLP.
- Forwards the TLP through one registered output stage with full ready/valid backpressure.
- Discards and flags completions whose tag maps to no consumer.

Parameters:
- DATA_W, 256, data bus width in bits.
- KEEP_W, 8, keep width (one bit per dword).
- TUSER_W, 8, sideband width, passed through unchanged.
- TAG_W, 8, completion tag width; bits [TAG_W-1:TAG_W-2] select the destination.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cpl_data  in  DATA_W  completion beat data
- cpl_keep  in  KEEP_W  dword keep
- cpl_user  in  TUSER_W  sideband
- cpl_sop  in  1  first beat of TLP
- cpl_eop  in  1  last beat of TLP
- cpl_tag  in  TAG_W  completion tag, valid on the SOP beat
- cpl_valid  in  1  beat valid
- cpl_rdy  out  1  beat accepted when cpl_valid&cpl_rdy
- {rxd,rxs,txd}_m_axis_tx_tready  in  1 each  destination ready
- {rxd,rxs,txd}_m_axis_tx_tdata  out  DATA_W each  forwarded data
- {rxd,rxs,txd}_m_axis_tx_tkeep  out  KEEP_W each  forwarded keep
- {rxd,rxs,txd}_m_axis_tx_sop / _eop  out  1 each  packet delimiters
- {rxd,rxs,txd}_m_axis_tx_tvalid  out  1 each  destination valid
- {rxd,rxs,txd}_m_axis_tx_tuser  out  TUSER_W each  forwarded sideband
- cpl_unroute_err  out  1  one-cycle pulse per discarded TLP

Behaviour:
- Reset: one clock `clk`; `rst_n` asynchronous assert, synchronous deassert. All tvalid, sop, eop, cpl_unroute_err = 0; data/keep/user = 0; FSM = IDLE.
- Tag decode, top two tag bits: 2'b00 → rxd, 2'b01 → rxs, 2'b10 → txd, 2'b11 → unrouted.
- FSM states: IDLE, FWD, DROP.
  - IDLE: an accepted SOP beat latches the destination. If routed and not EOP → FWD. If routed and EOP → stays IDLE (single-beat TLP). If unrouted → DROP, or stays IDLE when that beat is also EOP.
  - FWD: the held destination is used; tag is ignored. An accepted EOP beat → IDLE.
  - DROP: cpl_rdy = 1 unconditionally; beats are consumed and never forwarded. An accepted EOP beat → IDLE.
  - cpl_unroute_err pulses in the cycle after the unrouted SOP beat is accepted.
- A beat without SOP while in IDLE is a protocol violation. It is consumed and dropped, with no error pulse.
- A SOP beat while in FWD or DROP is treated as an ordinary data beat; no resync.
- Output stage: one shared register holding data/keep/user/sop/eop/dest plus out_vld.
  - Only the tvalid of the selected destination is asserted. The other two destinations' tvalid = 0, and their data outputs mirror the register.
  - Non-DROP beats: cpl_rdy = !out_vld | tready[dest_reg]. This is full-throughput pipelining: 1 beat/cycle when the destination is ready.
  - Latency is 1 cycle from accepted beat to tvalid.
  - Output payload is held stable while tvalid & !tready.
- A new TLP may begin in the cycle the previous EOP drains. Back-to-back TLPs to different destinations need no bubble.
- cpl_unroute_err is never asserted in the same cycle as reset deassertion.
- Reset mid-packet: everything is discarded. The next beat must be a SOP.

Optional Feature:
- Macro INGRESS_CPL_STAT_EN.
- Defined: adds four 16-bit saturating counter outputs, each cleared by reset:
  - stat_rxd_pkts, stat_rxs_pkts, stat_txd_pkts, incremented on each EOP handed off to that destination (tvalid & tready & eop);
  - stat_drop_pkts, incremented on each unrouted SOP.
- Undefined: the ports and logic are absent; the rest of the behaviour is identical.

Test Plan:
- Reset, then a 3-beat TLP with tag 8'h05 and all tready = 1 → rxd tvalid for 3 consecutive cycles, starting 1 cycle after the first accept; sop on beat 0, eop on beat 2; rxs/txd tvalid stay 0.
- TLPs with tags 8'h41 (2 beats) and 8'h82 (1 beat) sent back-to-back → rxs then txd, with no idle cycle between them; cpl_rdy constantly 1.
- 4-beat TLP with tag 8'hC3 → cpl_rdy = 1 on every beat, no tvalid on any output, cpl_unroute_err = 1 for exactly one cycle; a following TLP with tag 8'h00 is routed to rxd.
- rxd_tready held 0 for 5 cycles mid-TLP (tag 8'h10) → rxd tdata/keep/sop/eop stable, cpl_rdy = 0 while out_vld, no beat lost or duplicated after tready = 1.
- rst_n asserted on beat 2 of a 4-beat TLP → all tvalid = 0 immediately (asynchronous); after release, a new SOP with tag 8'h80 routes to txd.
- With INGRESS_CPL_STAT_EN: 3 rxd, 2 rxs, 1 txd and 2 unrouted TLPs → counters read 3/2/1/2; after 70000 rxd TLPs, stat_rxd_pkts = 16'hFFFF.
